// File: rtl/microwave_cook_controller.sv
// microwave_cook_controller
//   Sequencing core of the microwave front panel. Takes debounced one-cycle
//   button pulses plus the door switch level, runs the cook state machine,
//   counts remaining seconds down and sweeps a 0..15 rotating LED index.
//
//   Ports
//     clk, rst_n      : system clock, asynchronous active-low reset
//     start_btn       : pulse, start / resume
//     stop_btn        : pulse, pause / cancel
//     add_btn         : pulse, add ADD_SEC seconds
//     mode_btn        : pulse, cycle power mode 01 -> 10 -> 11 -> 01
//     door_open       : level, 1 = door open
//     led_pos[3:0]    : rotating LED index to the decoder
//     cooking         : 1 only in COOK
//     idle            : 1 only in IDLE
//     mode[1:0]       : power mode (01 low, 10 medium, 11 high)
//     remaining_sec   : seconds left
//     done            : 1 only in DONE
//
//   Handshake: there is no valid/ready pairing here. Every button input is a
//   single-cycle pulse that is consumed on the clock edge where it is high;
//   all outputs come straight from flops and reflect that edge one cycle
//   after the pulse. Within one cycle the pulses rank
//   stop > door > start > add > mode; a lower one is dropped when a higher
//   one acts.
module microwave_cook_controller #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int SWEEP_TICKS   = 6250000,
  parameter int ADD_SEC       = 30,
  parameter int MAX_SEC       = 999,
  parameter int DONE_SEC      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       add_btn,
  input  logic       mode_btn,
  input  logic       door_open,
  output logic [3:0] led_pos,
  output logic       cooking,
  output logic       idle,
  output logic [1:0] mode,
  output logic [9:0] remaining_sec,
  output logic       done
);

  localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SWP_W  = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;
  localparam int DCNT_W = (DONE_SEC > 1) ? $clog2(DONE_SEC) : 1;
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
  localparam logic [SWP_W-1:0]  SWP_LAST  = SWP_W'(SWEEP_TICKS - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DONE_SEC - 1);
  localparam logic [10:0]       ADD_EXT   = 11'(ADD_SEC);
  localparam logic [10:0]       MAX_EXT   = 11'(MAX_SEC);

  typedef enum logic [2:0] {IDLE, SET, COOK, PAUSE, DONE} state_t;

  state_t              state_q, state_d;
  logic [SEC_W-1:0]    sec_q, sec_d;       // one-second prescaler
  logic [SWP_W-1:0]    sweep_q, sweep_d;   // LED sweep prescaler
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;     // seconds spent in DONE
  logic [3:0]          led_q, led_d;
  logic [9:0]          rem_q, rem_d;
  logic [1:0]          mode_q, mode_d;

  logic       sec_wrap, sweep_wrap, to_idle, start_fresh;
  logic [9:0] rem_after_tick;

  // remaining + ADD_SEC, clamped to MAX_SEC; computed one bit wider so the
  // carry cannot wrap before the compare.
  function automatic logic [9:0] sat_add(input logic [9:0] base);
    logic [10:0] sum;
    sum = {1'b0, base} + ADD_EXT;
    if (sum > MAX_EXT) sat_add = MAX_EXT[9:0];
    else               sat_add = sum[9:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sec_q   <= '0;
      sweep_q <= '0;
      dcnt_q  <= '0;
      led_q   <= 4'd0;
      rem_q   <= 10'd0;
      mode_q  <= 2'b10;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      sweep_q <= sweep_d;
      dcnt_q  <= dcnt_d;
      led_q   <= led_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    sweep_d     = sweep_q;
    dcnt_d      = dcnt_q;
    led_d       = led_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    to_idle     = 1'b0;
    start_fresh = 1'b0;

    sec_wrap   = (sec_q == SEC_LAST);
    sweep_wrap = (sweep_q == SWP_LAST);
    // Value remaining would take from this cycle's countdown alone.
    rem_after_tick = (sec_wrap && rem_q != 10'd0) ? rem_q - 10'd1 : rem_q;

    case (state_q)
      IDLE: begin
        // stop has nothing to do in IDLE but still outranks the rest.
        if (!stop_btn) begin
          if (start_btn && !door_open) begin
            rem_d       = sat_add(10'd0);
            start_fresh = 1'b1;
          end else if (add_btn) begin
            rem_d   = sat_add(rem_q);
            state_d = SET;
          end else if (mode_btn) begin
            mode_d = (mode_q == 2'b11) ? 2'b01 : mode_q + 2'd1;
          end
        end
      end

      SET: begin
        if (stop_btn) begin
          to_idle = 1'b1;
        end else if (start_btn && !door_open) begin
          start_fresh = 1'b1;
        end else if (add_btn) begin
          rem_d = sat_add(rem_q);
        end else if (mode_btn) begin
          mode_d = (mode_q == 2'b11) ? 2'b01 : mode_q + 2'd1;
        end
      end

      COOK: begin
        if (stop_btn || door_open) begin
          // Counters simply stop advancing; PAUSE keeps them as they are.
          state_d = PAUSE;
        end else begin
          sec_d = sec_wrap ? '0 : sec_q + 1'b1;
          rem_d = add_btn ? sat_add(rem_after_tick) : rem_after_tick;
          if (!add_btn && sec_wrap && rem_q <= 10'd1) begin
            // Last second expired: the LED index stays where it was.
            state_d = DONE;
            dcnt_d  = '0;
          end else begin
            sweep_d = sweep_wrap ? '0 : sweep_q + 1'b1;
            if (sweep_wrap) led_d = led_q + 4'd1;
          end
        end
      end

      PAUSE: begin
        if (stop_btn) begin
          to_idle = 1'b1;
        end else if (start_btn && !door_open) begin
          state_d = COOK;   // resume with prescalers untouched
        end else if (add_btn) begin
          rem_d = sat_add(rem_q);
        end
      end

      DONE: begin
        if (stop_btn || door_open) begin
          to_idle = 1'b1;
        end else if (sec_wrap) begin
          sec_d = '0;
          if (dcnt_q == DCNT_LAST) to_idle = 1'b1;
          else                     dcnt_d  = dcnt_q + 1'b1;
        end else begin
          sec_d = sec_q + 1'b1;
        end
      end

      default: to_idle = 1'b1;
    endcase

    if (start_fresh) begin
      state_d = COOK;
      sec_d   = '0;
      sweep_d = '0;
    end

    if (to_idle) begin
      state_d = IDLE;
      rem_d   = 10'd0;
      led_d   = 4'd0;
      sec_d   = '0;
      sweep_d = '0;
      dcnt_d  = '0;
    end
  end

  assign led_pos       = led_q;
  assign mode          = mode_q;
  assign remaining_sec = rem_q;
  assign cooking       = (state_q == COOK);
  assign idle          = (state_q == IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed testbench for microwave_cook_controller with small timing
// parameters (1 s = 10 clks, sweep = 2 clks, ADD_SEC = 3, MAX_SEC = 7,
// DONE_SEC = 2). Inputs change on the falling edge; outputs are sampled on
// the falling edge (or mid-cycle for the asynchronous reset check).
module tb_microwave_cook_controller;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_STOP  = 4'b0010;
  localparam logic [3:0] B_ADD   = 4'b0100;
  localparam logic [3:0] B_MODE  = 4'b1000;

  logic       clk;
  logic       rst_n;
  logic       start_btn, stop_btn, add_btn, mode_btn, door_open;
  logic [3:0] led_pos;
  logic       cooking, idle, done;
  logic [1:0] mode;
  logic [9:0] remaining_sec;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];

  microwave_cook_controller #(
    .TICKS_PER_SEC(10),
    .SWEEP_TICKS  (2),
    .ADD_SEC      (3),
    .MAX_SEC      (7),
    .DONE_SEC     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_btn    (start_btn),
    .stop_btn     (stop_btn),
    .add_btn      (add_btn),
    .mode_btn     (mode_btn),
    .door_open    (door_open),
    .led_pos      (led_pos),
    .cooking      (cooking),
    .idle         (idle),
    .mode         (mode),
    .remaining_sec(remaining_sec),
    .done         (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // drivers: called on a falling edge, return on the next falling edge
  task automatic press(input logic [3:0] m);
    start_btn = m[0];
    stop_btn  = m[1];
    add_btn   = m[2];
    mode_btn  = m[3];
    @(negedge clk);
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    add_btn   = 1'b0;
    mode_btn  = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start_btn = 1'b0; stop_btn = 1'b0; add_btn = 1'b0; mode_btn = 1'b0;
    door_open = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(1);

    // reset state
    check("rst_idle",    idle, 1);
    check("rst_mode",    mode, 2'b10);
    check("rst_rem",     remaining_sec, 0);
    check("rst_led",     led_pos, 0);
    check("rst_cooking", cooking, 0);
    check("rst_done",    done, 0);

    // add once, start, full countdown into DONE and back to IDLE
    press(B_ADD);
    check("set_rem", remaining_sec, 3);
    check("set_idle", idle, 0);
    exp_q.push_back(10'd3); exp_q.push_back(10'd2);
    exp_q.push_back(10'd1); exp_q.push_back(10'd0);
    press(B_START);                                 // edge S
    check("a_cooking", cooking, 1);
    check("a_rem0", remaining_sec, exp_q.pop_front());
    wait_clks(2);
    check("a_led_s2", led_pos, 1);
    wait_clks(7);
    check("a_rem_s9", remaining_sec, 3);
    wait_clks(1);
    check("a_rem1", remaining_sec, exp_q.pop_front());
    check("a_led_s10", led_pos, 5);
    wait_clks(10);
    check("a_rem2", remaining_sec, exp_q.pop_front());
    check("a_led_s20", led_pos, 10);
    wait_clks(9);
    check("a_cook_s29", cooking, 1);
    check("a_led_s29", led_pos, 14);
    wait_clks(1);
    check("a_rem3", remaining_sec, exp_q.pop_front());
    check("a_done", done, 1);
    check("a_cook_off", cooking, 0);
    check("a_led_held", led_pos, 14);
    wait_clks(19);
    check("a_done_d19", done, 1);
    wait_clks(1);
    check("a_done_off", done, 0);
    check("a_back_idle", idle, 1);
    check("a_led_clr", led_pos, 0);

    // saturation and mode cycling
    press(B_ADD);
    press(B_ADD);
    check("b_rem6", remaining_sec, 6);
    press(B_ADD);
    check("b_rem_sat", remaining_sec, 7);
    press(B_MODE);
    check("b_mode11", mode, 2'b11);
    press(B_MODE);
    check("b_mode01", mode, 2'b01);

    // cook from 7, pause at 5 with door, resume, LED wrap
    press(B_START);                                 // edge S
    wait_clks(25);
    check("b_rem_s25", remaining_sec, 5);
    check("b_led_s25", led_pos, 12);
    door_open = 1'b1;
    wait_clks(1);
    check("b_pause_cook", cooking, 0);
    check("b_pause_rem", remaining_sec, 5);
    check("b_pause_led", led_pos, 12);
    wait_clks(5);
    press(B_START);                                 // door still open
    check("b_start_door", cooking, 0);
    check("b_frozen_rem", remaining_sec, 5);
    check("b_frozen_led", led_pos, 12);
    door_open = 1'b0;
    press(B_START);                                 // edge R
    check("b_resume", cooking, 1);
    check("b_resume_led", led_pos, 12);
    wait_clks(1);
    check("b_led_r1", led_pos, 13);
    wait_clks(3);
    check("b_rem_r4", remaining_sec, 5);
    wait_clks(1);
    check("b_rem_r5", remaining_sec, 4);
    check("b_led_r5", led_pos, 15);
    wait_clks(2);
    check("b_led_wrap", led_pos, 0);
    press(B_STOP);
    check("b_stop_pause", cooking, 0);
    check("b_stop_notidle", idle, 0);
    check("b_stop_rem", remaining_sec, 4);
    press(B_STOP);
    check("b_cancel_idle", idle, 1);
    check("b_cancel_rem", remaining_sec, 0);
    check("b_cancel_led", led_pos, 0);

    // start+stop together in SET, then quick-start
    press(B_ADD);
    press(B_START | B_STOP);
    check("c_ss_idle", idle, 1);
    check("c_ss_rem", remaining_sec, 0);
    press(B_START);                                 // edge S2
    check("c_qs_cook", cooking, 1);
    check("c_qs_rem", remaining_sec, 3);

    // add coincident with the 1 -> 0 decrement
    wait_clks(29);
    check("c_rem_s29", remaining_sec, 1);
    press(B_ADD);
    check("c_coinc_rem", remaining_sec, 3);
    check("c_coinc_cook", cooking, 1);
    check("c_coinc_done", done, 0);
    wait_clks(10);
    check("c_rem_s40", remaining_sec, 2);

    // asynchronous reset mid-COOK
    #3 rst_n = 1'b0;
    #1;
    check("r_cooking", cooking, 0);
    check("r_idle", idle, 1);
    check("r_rem", remaining_sec, 0);
    check("r_led", led_pos, 0);
    check("r_mode", mode, 2'b10);
    check("r_done", done, 0);
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(2);
    check("r_after_idle", idle, 1);

    // final report
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
